cpu_mc: RTL

- Parametrised multi-cycle successor to the single-cycle 16-bit core.
- Same 3-bit-opcode ISA, generalised to XLEN-wide datapath and NREG registers.
- One unified memory port with a req/ready handshake, so instruction and data memory may have variable latency.
- Adds a defined halt instruction, illegal-opcode detection, a retire strobe and a debug register read port.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_mc_if.sv | 22 ++
 rtl/cpu_mc_regfile.sv | 41 ++++
 rtl/cpu_mc.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA constants, instruction layout and FSM encoding for the multi-cycle core.
package cpu_pkg;

   localparam logic [2:0] OP_RRR  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_RSVD = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NAND = 4'd5;
   localparam logic [3:0] ALU_SHL  = 4'd6;
   localparam logic [3:0] ALU_SHR  = 4'd7;

   localparam logic [6:0] HALT_IMM = 7'h01;

   localparam logic [1:0] StFetch = 2'd0;
   localparam logic [1:0] StExec  = 2'd1;
   localparam logic [1:0] StMem   = 2'd2;
   localparam logic [1:0] StHalt  = 2'd3;

   // imm7 and imm10 alias the low bits of this layout.
   typedef struct packed {
      logic [2:0] op;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [3:0] alu_op;
      logic [2:0] rc;
   } instr_t;

   function automatic logic is_halt(input logic [15:0] ir);
      return (ir[15:13] == OP_JALR) && (ir[6:0] == HALT_IMM);
   endfunction

endpackage

// File: rtl/cpu_mc_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface cpu_mc_if #(
   parameter int unsigned XLEN = 16,
   parameter int unsigned AW   = 16
);
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/cpu_mc_regfile.sv
// Register file: two combinational read ports, a debug read port and one synchronous write port.
module cpu_mc_regfile #(
   parameter int unsigned XLEN = 16,
   parameter int unsigned NREG = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      ra_sel_i,
   output logic [XLEN-1:0] ra_data_o,
   input  logic [2:0]      rb_sel_i,
   output logic [XLEN-1:0] rb_data_o,
   input  logic [2:0]      dbg_sel_i,
   output logic [XLEN-1:0] dbg_data_o,
   input  logic            we_i,
   input  logic [2:0]      waddr_i,
   input  logic [XLEN-1:0] wdata_i
);

   logic [XLEN-1:0] regs_q [NREG];

   // r0 and unimplemented indices read as zero.
   function automatic logic [XLEN-1:0] rd(input logic [2:0] sel);
      logic [XLEN-1:0] v;
      v = '0;
      if (sel != 3'd0 && 32'(sel) < NREG) v = regs_q[sel];
      return v;
   endfunction

   assign ra_data_o  = rd(ra_sel_i);
   assign rb_data_o  = rd(rb_sel_i);
   assign dbg_data_o = rd(dbg_sel_i);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else if (we_i && waddr_i != 3'd0 && 32'(waddr_i) < NREG) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle core: FETCH -> EXEC (-> MEM) -> FETCH over one shared memory port, with HALT.
module cpu_mc
   import cpu_pkg::*;
#(
   parameter int unsigned     XLEN     = 16,
   parameter int unsigned     AW       = 16,
   parameter int unsigned     NREG     = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   cpu_mc_if.master        mem,
   output logic            halted,
   output logic            retired,
   output logic            illegal,
   output logic [XLEN-1:0] dbg_pc,
   input  logic [2:0]      dbg_sel,
   output logic [XLEN-1:0] dbg_data
);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   instr_t          ins;
   logic [2:0]      rx_sel;
   logic [XLEN-1:0] rs_b, rs_x;
   logic [XLEN-1:0] sext7, lui_val, pc_inc, ea, alu_res;
   logic [3:0]      shamt;
   logic            rf_we;
   logic [XLEN-1:0] rf_wdata;
   logic            xfer;

   assign ins     = instr_t'(ir_q);
   // Second read port serves rC for RRR and rA (store data / compare) otherwise.
   assign rx_sel  = (ins.op == OP_RRR) ? ins.rc : ins.ra;
   assign sext7   = XLEN'($signed(ir_q[6:0]));
   assign lui_val = XLEN'({ir_q[9:0], 6'b0});
   assign pc_inc  = pc_q + XLEN'(1);
   assign ea      = rs_b + sext7;
   assign shamt   = rs_x[3:0];
   assign xfer    = mem.mem_req && mem.mem_ready;

   cpu_mc_regfile #(
      .XLEN(XLEN),
      .NREG(NREG)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra_sel_i  (ins.rb),
      .ra_data_o (rs_b),
      .rb_sel_i  (rx_sel),
      .rb_data_o (rs_x),
      .dbg_sel_i (dbg_sel),
      .dbg_data_o(dbg_data),
      .we_i      (rf_we),
      .waddr_i   (ins.ra),
      .wdata_i   (rf_wdata)
   );

   always_comb begin
      alu_res = '0;
      case (ins.alu_op)
         ALU_ADD:  alu_res = rs_b + rs_x;
         ALU_SUB:  alu_res = rs_b - rs_x;
         ALU_AND:  alu_res = rs_b & rs_x;
         ALU_OR:   alu_res = rs_b | rs_x;
         ALU_XOR:  alu_res = rs_b ^ rs_x;
         ALU_NAND: alu_res = ~(rs_b & rs_x);
         ALU_SHL:  alu_res = rs_b << shamt;
         ALU_SHR:  alu_res = rs_b >> shamt;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rf_we    = 1'b0;
      rf_wdata = '0;
      retired  = 1'b0;
      illegal  = 1'b0;

      case (state_q)
         StFetch: begin
            if (xfer) begin
               ir_d    = mem.mem_rdata[15:0];
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StFetch;
            pc_d    = pc_inc;
            retired = 1'b1;
            case (ins.op)
               OP_RRR: begin
                  rf_we    = 1'b1;
                  rf_wdata = alu_res;
               end
               OP_ADDI: begin
                  rf_we    = 1'b1;
                  rf_wdata = ea;
               end
               OP_LUI: begin
                  rf_we    = 1'b1;
                  rf_wdata = lui_val;
               end
               OP_SW, OP_LW: begin
                  addr_d  = AW'(ea);
                  wdata_d = rs_x;
                  pc_d    = pc_q;
                  retired = 1'b0;
                  state_d = StMem;
               end
               OP_BEQ: begin
                  if (rs_x == rs_b) pc_d = pc_inc + sext7;
               end
               OP_JALR: begin
                  if (is_halt(ir_q)) begin
                     pc_d    = pc_q;
                     state_d = StHalt;
                  end else begin
                     rf_we    = 1'b1;
                     rf_wdata = pc_inc;
                     pc_d     = rs_b;
                  end
               end
               default: illegal = 1'b1;
            endcase
         end
         StMem: begin
            if (xfer) begin
               rf_we    = (ins.op == OP_LW);
               rf_wdata = mem.mem_rdata;
               pc_d     = pc_inc;
               retired  = 1'b1;
               state_d  = StFetch;
            end
         end
         StHalt: ;
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Request is gated by rst_n so an in-flight transfer is abandoned as soon as reset asserts.
   assign mem.mem_req   = rst_n && (state_q == StFetch || state_q == StMem);
   assign mem.mem_we    = (state_q == StMem) && (ins.op == OP_SW);
   assign mem.mem_addr  = (state_q == StMem) ? addr_q : AW'(pc_q);
   assign mem.mem_wdata = wdata_q;

   assign halted = (state_q == StHalt);
   assign dbg_pc = pc_q;

endmodule
